// File: rtl/ctrl_pkg.sv
// Shared types and constants for the instruction sequencing controller.
// Holds the state encoding, opcode/ALU codes, instr field positions and per-state drive helpers.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    localparam logic [3:0] OP_MOVI = 4'd0;
    localparam logic [3:0] OP_ALUR = 4'd1;
    localparam logic [3:0] OP_ALUI = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int ALU_MSB = 27;
    localparam int ALU_LSB = 25;
    localparam int SH_MSB  = 24;
    localparam int SH_LSB  = 23;
    localparam int RN_MSB  = 19;
    localparam int RN_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 12;
    localparam int RM_MSB  = 3;
    localparam int RM_LSB  = 0;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] alu_op;
        logic [1:0] shift_op;
        logic [3:0] rn;
        logic [3:0] rd;
        logic [3:0] rm;
        logic       legal;
    } fields_t;

    typedef struct packed {
        logic       waiting;
        logic       done;
        logic       err;
        logic       wb_sel;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] r_addr;
        logic       en_a;
        logic       en_b;
        logic [1:0] shift_op;
        logic       sel_a;
        logic       sel_b;
        logic [2:0] alu_op;
        logic       en_c;
        logic       en_status;
    } drive_t;

    function automatic drive_t drive_wait();
        drive_t d;
        d = '0;
        d.waiting = 1'b1;
        return d;
    endfunction

    function automatic drive_t drive_err();
        drive_t d;
        d = '0;
        d.err = 1'b1;
        return d;
    endfunction

    function automatic drive_t drive_load_a(logic [3:0] rn);
        drive_t d;
        d = '0;
        d.r_addr = rn;
        d.en_a   = 1'b1;
        return d;
    endfunction

    function automatic drive_t drive_load_b(logic [3:0] rm);
        drive_t d;
        d = '0;
        d.r_addr = rm;
        d.en_b   = 1'b1;
        return d;
    endfunction

    // MOVI runs as 0 + imm12: A mux picks zero, B mux picks the immediate, ALU adds.
    function automatic drive_t drive_exec(fields_t f);
        drive_t d;
        d = '0;
        d.en_c     = 1'b1;
        d.shift_op = f.shift_op;
        if (f.opcode == OP_MOVI) begin
            d.alu_op = ALU_ADD;
            d.sel_a  = 1'b1;
            d.sel_b  = 1'b1;
        end else begin
            d.alu_op = f.alu_op;
            d.sel_b  = (f.opcode == OP_ALUI);
        end
        d.en_status = (f.opcode == OP_CMP) || (f.opcode == OP_ALUR);
        d.done      = (f.opcode == OP_CMP);
        return d;
    endfunction

    function automatic drive_t drive_wb(logic [3:0] rd);
        drive_t d;
        d = '0;
        d.w_en   = 1'b1;
        d.w_addr = rd;
        d.wb_sel = 1'b0;
        d.done   = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/controller_if.sv
// Handshake and datapath-drive bundle between the controller and its environment.
interface controller_if;
    logic        start;
    logic [31:0] instr;
    logic        status_in;

    logic        wb_sel;
    logic [3:0]  w_addr;
    logic        w_en;
    logic [3:0]  r_addr;
    logic        en_A;
    logic        en_B;
    logic [1:0]  shift_op;
    logic        sel_A;
    logic        sel_B;
    logic [2:0]  ALU_op;
    logic        en_C;
    logic        en_status;
    logic        waiting;
    logic        done;
    logic        err;
    logic        z_out;

    modport master (
        output start, instr, status_in,
        input  wb_sel, w_addr, w_en, r_addr, en_A, en_B, shift_op, sel_A, sel_B,
               ALU_op, en_C, en_status, waiting, done, err, z_out
    );

    modport slave (
        input  start, instr, status_in,
        output wb_sel, w_addr, w_en, r_addr, en_A, en_B, shift_op, sel_A, sel_B,
               ALU_op, en_C, en_status, waiting, done, err, z_out
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational split of a 32-bit instruction word into fields plus an opcode legality flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output fields_t     fld
);
    // Bits 22:20 are reserved and imm12 beyond Rm goes to the datapath directly.
    logic unused_bits;
    assign unused_bits = ^{ir[22:20], ir[11:4]};

    always_comb begin
        fld          = '0;
        fld.opcode   = ir[OPC_MSB:OPC_LSB];
        fld.alu_op   = ir[ALU_MSB:ALU_LSB];
        fld.shift_op = ir[SH_MSB:SH_LSB];
        fld.rn       = ir[RN_MSB:RN_LSB];
        fld.rd       = ir[RD_MSB:RD_LSB];
        fld.rm       = ir[RM_MSB:RM_LSB];
        fld.legal    = (fld.opcode <= OP_CMP);
    end
endmodule

// File: rtl/controller.sv
// Multi-cycle sequencer for a register-file/ALU datapath; outputs are registered alongside state.
module controller
    import ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    controller_if.slave bus
);
    state_e      state;
    logic [31:0] ir;
    logic [31:0] dec_src;
    fields_t     fld;
    drive_t      drv;

    // In WAIT the decode looks at live instr so the first state's drive is ready on the capture edge.
    assign dec_src = (state == S_WAIT) ? bus.instr : ir;

    ctrl_decode u_decode (
        .ir  (dec_src),
        .fld (fld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAIT;
            ir    <= '0;
            drv   <= drive_wait();
        end else begin
            case (state)
                S_WAIT: begin
                    if (bus.start) begin
                        ir <= bus.instr;
                        if (!fld.legal) begin
                            state <= S_ERR;
                            drv   <= drive_err();
                        end else if (fld.opcode == OP_MOVI) begin
                            state <= S_EXEC;
                            drv   <= drive_exec(fld);
                        end else begin
                            state <= S_LOAD_A;
                            drv   <= drive_load_a(fld.rn);
                        end
                    end else begin
                        drv <= drive_wait();
                    end
                end
                S_LOAD_A: begin
                    if (fld.opcode == OP_ALUI) begin
                        state <= S_EXEC;
                        drv   <= drive_exec(fld);
                    end else begin
                        state <= S_LOAD_B;
                        drv   <= drive_load_b(fld.rm);
                    end
                end
                S_LOAD_B: begin
                    state <= S_EXEC;
                    drv   <= drive_exec(fld);
                end
                S_EXEC: begin
                    if (fld.opcode == OP_CMP) begin
                        state <= S_WAIT;
                        drv   <= drive_wait();
                    end else begin
                        state <= S_WB;
                        drv   <= drive_wb(fld.rd);
                    end
                end
                default: begin
                    state <= S_WAIT;
                    drv   <= drive_wait();
                end
            endcase
        end
    end

    assign bus.wb_sel    = drv.wb_sel;
    assign bus.w_addr    = drv.w_addr;
    assign bus.w_en      = drv.w_en;
    assign bus.r_addr    = drv.r_addr;
    assign bus.en_A      = drv.en_a;
    assign bus.en_B      = drv.en_b;
    assign bus.shift_op  = drv.shift_op;
    assign bus.sel_A     = drv.sel_a;
    assign bus.sel_B     = drv.sel_b;
    assign bus.ALU_op    = drv.alu_op;
    assign bus.en_C      = drv.en_c;
    assign bus.en_status = drv.en_status;
    assign bus.waiting   = drv.waiting;
    assign bus.done      = drv.done;
    assign bus.err       = drv.err;
    assign bus.z_out     = bus.status_in;
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 clk  input  1  system clock; all state updates on the posedge.
REQ-002 rst  input  1  reset; asynchronous, active-high.
REQ-003 start  input  1  request to execute the instruction on instr; sampled only in WAIT.
REQ-004 instr  input  32  fields: [31:28] opcode, [27:25] alu_op, [24:23] shift_op, [19:16] Rn, [15:12] Rd, [11:0] imm12, [3:0] Rm.
REQ-005 status_in  input  1  datapath Z flag; exported unchanged on z_out.
REQ-006 Datapath drive outputs: wb_sel 1, w_addr 4, w_en 1, r_addr 4, en_A 1, en_B 1, shift_op 2, sel_A 1, sel_B 1, ALU_op 3, en_C 1, en_status 1.
REQ-007 waiting  output  1  high exactly while in WAIT.
REQ-008 done  output  1  one-cycle pulse in the final state of a legal instruction.
REQ-009 err  output  1  one-cycle pulse on an illegal opcode.
REQ-010 z_out  output  1  equals status_in combinationally.

Function
REQ-011 The block SHALL capture instr into an internal instruction register at the clock edge on which start=1 in WAIT; all later outputs use the captured copy, not live instr.
REQ-012 Opcodes: 0 MOVI (Rd<-0+imm12), 1 ALUR (Rd<-Rn op shift(Rm)), 2 ALUI (Rd<-Rn op imm12), 3 CMP (status<-Rn op shift(Rm), no writeback), 4-15 illegal.
REQ-013 States: WAIT, LOAD_A, LOAD_B, EXEC, WB, ERR.
REQ-014 Transitions from WAIT on start: MOVI->EXEC; ALUR, CMP->LOAD_A->LOAD_B->EXEC; ALUI->LOAD_A->EXEC; illegal->ERR.
REQ-015 From EXEC: CMP->WAIT; all others->WB. WB->WAIT; ERR->WAIT.
REQ-016 Outputs by state:
- LOAD_A: r_addr=Rn, en_A=1.
- LOAD_B: r_addr=Rm, en_B=1.
- EXEC: en_C=1, ALU_op=alu_op (MOVI forces ALU_op=3'b000, sel_A=1), sel_B=1 for MOVI/ALUI else 0, shift_op=instr shift_op; en_status=1 for CMP and ALUR.
- WB: w_en=1, w_addr=Rd, wb_sel=0.
REQ-017 In any state, every output not listed in REQ-016 for that state SHALL be 0 (including r_addr, w_addr, ALU_op, shift_op).
REQ-018 Latency, counted from the start edge, to return to WAIT: MOVI 3, ALUI 4, CMP 4, ALUR 5, illegal 2 cycles.
REQ-019 done SHALL be 1 in WB, and in EXEC for CMP only; err SHALL be 1 only in ERR.
REQ-020 start asserted outside WAIT SHALL be ignored without queuing; start held high through WAIT re-entry SHALL launch the next instruction on that edge.
REQ-021 An immediate operand is delivered to the datapath by the enclosing top level, not by this block.
REQ-022 Rd=Rn=Rm SHALL need no special handling; the datapath A, B and C registers isolate the read from the writeback.

Reset
REQ-023 When rst=1, the block SHALL asynchronously enter WAIT, clear the instruction register, and force all enables, done and err to 0, so waiting=1.
REQ-024 Reset asserted mid-instruction SHALL abort it with no further w_en pulse; execution resumes only on a new start after rst falls.

Structure
REQ-025 Shared package ctrl_pkg SHALL hold the state enum, opcode constants (OP_MOVI..OP_CMP), ALU_op codes, and instr field bit-position constants.
REQ-026 One combinational sub-module, ctrl_decode, SHALL split the instruction register into fields and flag legality; the FSM and output logic stay in controller.

Verification
REQ-027 Reset then idle: rst pulse -> waiting=1, all enables/done/err=0.
REQ-028 MOVI Rd=5, imm12=0x07B -> EXEC has sel_A=1, sel_B=1, ALU_op=000, en_C=1; next cycle w_en=1, w_addr=5, wb_sel=0, done=1; WAIT reached 3 cycles after start.
REQ-029 ALUR Rn=1, Rm=2, Rd=3, alu_op=010, shift_op=01 -> r_addr 1 then 2 with en_A then en_B; EXEC ALU_op=010, shift_op=01, en_status=1; WB w_addr=3; 5-cycle latency.
REQ-030 CMP Rn=4, Rm=4 -> en_status=1 and done=1 in EXEC; w_en is never 1; 4-cycle latency.
REQ-031 Opcode 9 -> err=1 for one cycle, no enables asserted, WAIT after 2 cycles; start pulsed during LOAD_B is ignored.
REQ-032 ALUR launched, rst asserted in LOAD_B -> outputs clear in the same cycle, no w_en occurs, and waiting=1.
